// File: rtl/alu_reg_pkg.sv
// Shared encodings for the pipelined register-file + ALU datapath.
package alu_reg_pkg;

   localparam logic [3:0] FS_AND   = 4'd0;
   localparam logic [3:0] FS_OR    = 4'd1;
   localparam logic [3:0] FS_XOR   = 4'd2;
   localparam logic [3:0] FS_NOR   = 4'd3;
   localparam logic [3:0] FS_ADD   = 4'd4;
   localparam logic [3:0] FS_SUB   = 4'd5;
   localparam logic [3:0] FS_LSL   = 4'd6;
   localparam logic [3:0] FS_LSR   = 4'd7;
   localparam logic [3:0] FS_PASSB = 4'd8;
   localparam logic [3:0] FS_MUL   = 4'd9;

   localparam int unsigned ST_Z = 0;
   localparam int unsigned ST_N = 1;
   localparam int unsigned ST_C = 2;
   localparam int unsigned ST_V = 3;

   typedef enum logic [0:0] {StIdle, StMul} alu_state_e;

endpackage

// File: rtl/alu_reg_pipe_if.sv
// Op-issue and result bus between the control unit and the datapath.
interface alu_reg_pipe_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned AW    = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [AW-1:0]    addr_a;
   logic [AW-1:0]    addr_b;
   logic [AW-1:0]    addr_r;
   logic [3:0]       fs;
   logic             s;
   logic [WIDTH-1:0] k;
   logic             c0;
   logic             ld;
   logic [WIDTH-1:0] din;
   logic             w;
   logic             set_flags;
   logic             sb;
   logic             sd;
   logic [WIDTH-1:0] f;
   logic             f_valid;
   logic [3:0]       status;
   logic [WIDTH-1:0] dout;
   logic             dout_en;

   modport master (
      output in_valid, addr_a, addr_b, addr_r, fs, s, k, c0, ld, din, w, set_flags, sb, sd,
      input  in_ready, f, f_valid, status, dout, dout_en
   );

   modport slave (
      input  in_valid, addr_a, addr_b, addr_r, fs, s, k, c0, ld, din, w, set_flags, sb, sd,
      output in_ready, f, f_valid, status, dout, dout_en
   );
endinterface

// File: rtl/regfile_2r1w.sv
// Two asynchronous read ports, one synchronous write port, optional hardwired zero register.
module regfile_2r1w #(
   parameter int unsigned  WIDTH = 64,
   parameter int unsigned  NREGS = 32,
   parameter bit           ZR_EN = 1'b1,
   localparam int unsigned AW    = $clog2(NREGS)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [AW-1:0]    raddr_a_i,
   input  logic [AW-1:0]    raddr_b_i,
   output logic [WIDTH-1:0] rdata_a_o,
   output logic [WIDTH-1:0] rdata_b_o,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i
);
   localparam logic [AW-1:0] ZrAddr = AW'(NREGS - 1);

   logic [WIDTH-1:0] regs_q [NREGS];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (we_i && !(ZR_EN && waddr_i == ZrAddr)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = (ZR_EN && raddr_a_i == ZrAddr) ? '0 : regs_q[raddr_a_i];
   assign rdata_b_o = (ZR_EN && raddr_b_i == ZrAddr) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/alu_reg_pipe.sv
// Pipelined register-file + ALU datapath: registered result, forwarded writeback,
// iterative shift-add multiply and a sticky status register.
module alu_reg_pipe
   import alu_reg_pkg::*;
#(
   parameter int unsigned  WIDTH = 64,
   parameter int unsigned  NREGS = 32,
   parameter bit           ZR_EN = 1'b1,
   localparam int unsigned AW    = $clog2(NREGS)
) (
   input logic           clk_i,
   input logic           rst_ni,
   alu_reg_pipe_if.slave bus_io
);
   localparam int unsigned   LW      = $clog2(WIDTH);
   localparam logic [AW-1:0] ZrAddr  = AW'(NREGS - 1);
   localparam logic [LW-1:0] LastCnt = LW'(WIDTH - 1);

   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] f_q, f_d;
   logic             f_valid_q, f_valid_d;
   logic [3:0]       status_q, status_d;
   logic [AW-1:0]    addr_r_q, addr_r_d;
   logic             w_q, w_d;
   logic [WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_acc_q, mul_acc_d;
   logic [LW-1:0]    mul_cnt_q, mul_cnt_d;
   logic [AW-1:0]    mul_addr_q, mul_addr_d;
   logic             mul_w_q, mul_w_d, mul_sf_q, mul_sf_d;

   logic [WIDTH-1:0] rf_a, rf_b, op_a, op_b, alu_b, alu_res, mul_step;
   logic [WIDTH:0]   sum_ext;
   logic             alu_c, alu_v, wb_pend, accept;

   function automatic logic [3:0] mk_flags(logic [WIDTH-1:0] r, logic c, logic v);
      logic [3:0] fl;
      fl       = '0;
      fl[ST_Z] = (r == '0);
      fl[ST_N] = r[WIDTH-1];
      fl[ST_C] = c;
      fl[ST_V] = v;
      return fl;
   endfunction

   regfile_2r1w #(
      .WIDTH (WIDTH),
      .NREGS (NREGS),
      .ZR_EN (ZR_EN)
   ) u_regfile (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .raddr_a_i (bus_io.addr_a),
      .raddr_b_i (bus_io.addr_b),
      .rdata_a_o (rf_a),
      .rdata_b_o (rf_b),
      .we_i      (wb_pend),
      .waddr_i   (addr_r_q),
      .wdata_i   (f_q)
   );

   // The zero register never takes the forwarded value.
   assign wb_pend = f_valid_q & w_q;
   assign op_a = (wb_pend && addr_r_q == bus_io.addr_a && !(ZR_EN && bus_io.addr_a == ZrAddr))
                 ? f_q : rf_a;
   assign op_b = (wb_pend && addr_r_q == bus_io.addr_b && !(ZR_EN && bus_io.addr_b == ZrAddr))
                 ? f_q : rf_b;
   assign alu_b  = bus_io.s ? bus_io.k : op_b;
   assign accept = bus_io.in_valid && (state_q == StIdle);

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      sum_ext = '0;
      case (bus_io.fs)
         FS_AND:   alu_res = op_a & alu_b;
         FS_OR:    alu_res = op_a | alu_b;
         FS_XOR:   alu_res = op_a ^ alu_b;
         FS_NOR:   alu_res = ~(op_a | alu_b);
         FS_ADD: begin
            sum_ext = {1'b0, op_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, bus_io.c0};
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (op_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
         end
         FS_SUB: begin
            sum_ext = {1'b0, op_a} + {1'b0, ~alu_b} + {{WIDTH{1'b0}}, 1'b1};
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (op_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
         end
         FS_LSL:   alu_res = op_a << alu_b[LW-1:0];
         FS_LSR:   alu_res = op_a >> alu_b[LW-1:0];
         FS_PASSB: alu_res = alu_b;
         default:  alu_res = '0;
      endcase
   end

   assign mul_step = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);

   always_comb begin
      state_d    = state_q;
      f_d        = f_q;
      f_valid_d  = 1'b0;
      status_d   = status_q;
      addr_r_d   = addr_r_q;
      w_d        = w_q;
      mul_a_d    = mul_a_q;
      mul_b_d    = mul_b_q;
      mul_acc_d  = mul_acc_q;
      mul_cnt_d  = mul_cnt_q;
      mul_addr_d = mul_addr_q;
      mul_w_d    = mul_w_q;
      mul_sf_d   = mul_sf_q;
      case (state_q)
         StIdle: begin
            if (accept && !bus_io.ld && bus_io.fs == FS_MUL) begin
               // Destination is parked so the in-flight writeback keeps addr_r_q/w_q.
               state_d    = StMul;
               mul_a_d    = op_a;
               mul_b_d    = alu_b;
               mul_acc_d  = '0;
               mul_cnt_d  = '0;
               mul_addr_d = bus_io.addr_r;
               mul_w_d    = bus_io.w;
               mul_sf_d   = bus_io.set_flags;
            end else if (accept) begin
               f_d       = bus_io.ld ? bus_io.din : alu_res;
               f_valid_d = 1'b1;
               addr_r_d  = bus_io.addr_r;
               w_d       = bus_io.w;
               if (bus_io.set_flags) begin
                  status_d = bus_io.ld ? mk_flags(bus_io.din, 1'b0, 1'b0)
                                       : mk_flags(alu_res, alu_c, alu_v);
               end
            end
         end
         StMul: begin
            mul_acc_d = mul_step;
            mul_a_d   = mul_a_q << 1;
            mul_b_d   = mul_b_q >> 1;
            mul_cnt_d = mul_cnt_q + LW'(1);
            if (mul_cnt_q == LastCnt) begin
               state_d   = StIdle;
               f_d       = mul_step;
               f_valid_d = 1'b1;
               addr_r_d  = mul_addr_q;
               w_d       = mul_w_q;
               if (mul_sf_q) status_d = mk_flags(mul_step, 1'b0, 1'b0);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         f_q        <= '0;
         f_valid_q  <= 1'b0;
         status_q   <= '0;
         addr_r_q   <= '0;
         w_q        <= 1'b0;
         mul_a_q    <= '0;
         mul_b_q    <= '0;
         mul_acc_q  <= '0;
         mul_cnt_q  <= '0;
         mul_addr_q <= '0;
         mul_w_q    <= 1'b0;
         mul_sf_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         f_q        <= f_d;
         f_valid_q  <= f_valid_d;
         status_q   <= status_d;
         addr_r_q   <= addr_r_d;
         w_q        <= w_d;
         mul_a_q    <= mul_a_d;
         mul_b_q    <= mul_b_d;
         mul_acc_q  <= mul_acc_d;
         mul_cnt_q  <= mul_cnt_d;
         mul_addr_q <= mul_addr_d;
         mul_w_q    <= mul_w_d;
         mul_sf_q   <= mul_sf_d;
      end
   end

   assign bus_io.in_ready = (state_q == StIdle);
   assign bus_io.f        = f_q;
   assign bus_io.f_valid  = f_valid_q;
   assign bus_io.status   = status_q;
   assign bus_io.dout     = bus_io.sd ? f_q : (bus_io.sb ? op_b : '0);
   assign bus_io.dout_en  = bus_io.sb | bus_io.sd;

endmodule

// File: tb/tb_alu_reg_pipe.sv
// Scoreboard bench for alu_reg_pipe at WIDTH=8, NREGS=8 with the zero register enabled.
module tb_alu_reg_pipe;
   import alu_reg_pkg::*;

   localparam int unsigned W    = 8;
   localparam int unsigned NR   = 8;
   localparam int unsigned AWT  = 3;
   localparam int          MaxS = (1 << (W - 1)) - 1;
   localparam int          MinS = -(1 << (W - 1));
   localparam logic [AWT-1:0] ZR = 3'd7;

   typedef struct packed {
      logic [3:0]     fs;
      logic [AWT-1:0] a;
      logic [AWT-1:0] b;
      logic [AWT-1:0] r;
      logic           s;
      logic [W-1:0]   k;
      logic           c0;
      logic           ld;
      logic [W-1:0]   din;
      logic           w;
      logic           sf;
   } op_t;

   typedef struct packed {
      logic [W-1:0] f;
      logic [3:0]   st;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_reg_pipe_if #(.WIDTH(W), .AW(AWT)) bus ();

   alu_reg_pipe #(
      .WIDTH (W),
      .NREGS (NR),
      .ZR_EN (1'b1)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_io (bus)
   );

   exp_t         sb_q[$];
   logic [W-1:0] mreg [NR];
   logic [3:0]   mstat;
   int           n_vec = 0;
   int           n_bad = 0;

   function automatic op_t mk_alu(input logic [3:0] fs, input logic [AWT-1:0] a, b, r,
                                  input logic s, input logic [W-1:0] k, input logic c0,
                                  input logic w, input logic sf);
      op_t o;
      o = '{fs: fs, a: a, b: b, r: r, s: s, k: k, c0: c0, ld: 1'b0, din: '0, w: w, sf: sf};
      return o;
   endfunction

   function automatic op_t mk_ld(input logic [AWT-1:0] r, input logic [W-1:0] din,
                                 input logic sf);
      op_t o;
      o = '{fs: FS_AND, a: '0, b: '0, r: r, s: 1'b0, k: '0, c0: 1'b0, ld: 1'b1, din: din,
            w: 1'b1, sf: sf};
      return o;
   endfunction

   // Architectural model: ops complete in issue order, so forwarding is implicit.
   task automatic model_op(input op_t o);
      logic [W-1:0] a, b, res;
      logic         c, v;
      int           sa, sbv, sr;
      exp_t         e;
      a   = (o.a == ZR) ? '0 : mreg[o.a];
      b   = (o.b == ZR) ? '0 : mreg[o.b];
      b   = o.s ? o.k : b;
      c   = 1'b0;
      v   = 1'b0;
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      if (o.ld) res = o.din;
      else begin
         case (o.fs)
            FS_AND:   res = a & b;
            FS_OR:    res = a | b;
            FS_XOR:   res = a ^ b;
            FS_NOR:   res = ~(a | b);
            FS_ADD: begin
               res = a + b + W'(o.c0);
               c   = (int'(a) + int'(b) + int'(o.c0)) >= (1 << W);
               sr  = sa + sbv + int'(o.c0);
               v   = (sr > MaxS) || (sr < MinS);
            end
            FS_SUB: begin
               res = a - b;
               c   = (a >= b);
               sr  = sa - sbv;
               v   = (sr > MaxS) || (sr < MinS);
            end
            FS_LSL:   res = a << b[2:0];
            FS_LSR:   res = a >> b[2:0];
            FS_PASSB: res = b;
            FS_MUL:   res = a * b;
            default:  res = '0;
         endcase
      end
      if (o.w && o.r != ZR) mreg[o.r] = res;
      if (o.sf) mstat = {v, c, res[W-1], res == '0};
      e.f  = res;
      e.st = mstat;
      sb_q.push_back(e);
   endtask

   task automatic drive(input op_t o);
      bus.fs        = o.fs;
      bus.addr_a    = o.a;
      bus.addr_b    = o.b;
      bus.addr_r    = o.r;
      bus.s         = o.s;
      bus.k         = o.k;
      bus.c0        = o.c0;
      bus.ld        = o.ld;
      bus.din       = o.din;
      bus.w         = o.w;
      bus.set_flags = o.sf;
      bus.in_valid  = 1'b1;
   endtask

   // Called at a falling edge; returns at the falling edge of the cycle after acceptance.
   task automatic issue(input op_t o);
      model_op(o);
      drive(o);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.sb = 1'b0; bus.sd = 1'b0;
      drive(mk_alu(FS_AND, 0, 0, 0, 0, 0, 0, 0, 0));
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NR; i++) mreg[i] = '0;
      mstat = '0;
      n_vec++;
      if (bus.f !== '0 || bus.f_valid !== 1'b0 || bus.status !== 4'h0 || bus.in_ready !== 1'b1)
      begin
         n_bad++;
         $display("FAIL reset: f=%h f_valid=%b status=%b in_ready=%b, expected 00 0 0000 1",
                  bus.f, bus.f_valid, bus.status, bus.in_ready);
      end
   endtask

   task automatic test_fwd_add();
      op_t  ops[$];
      exp_t e;
      ops.push_back(mk_ld(3, 8'h05, 1'b0));
      ops.push_back(mk_alu(FS_ADD, 3, 0, 4, 1, 8'h07, 0, 0, 0));
      ops.push_back(mk_alu(FS_PASSB, 0, 3, 4, 0, 8'h00, 0, 0, 0));
      foreach (ops[i]) begin
         issue(ops[i]);
         e = sb_q.pop_front();
         n_vec++;
         if (bus.f_valid !== 1'b1 || bus.f !== e.f || bus.status !== e.st) begin
            n_bad++;
            $display("FAIL fwd_add[%0d]: f_valid=%b f=%h status=%b, expected 1 %h %b",
                     i, bus.f_valid, bus.f, bus.status, e.f, e.st);
         end
      end
      bus.sd = 1'b1;
      #1;
      n_vec++;
      if (bus.dout !== 8'h05 || bus.dout_en !== 1'b1) begin
         n_bad++;
         $display("FAIL dout_sd: dout=%h en=%b, expected 05 1", bus.dout, bus.dout_en);
      end
      bus.sd = 1'b0; bus.sb = 1'b1; bus.addr_b = 3'd3;
      #1;
      n_vec++;
      if (bus.dout !== 8'h05 || bus.dout_en !== 1'b1) begin
         n_bad++;
         $display("FAIL dout_sb: dout=%h en=%b, expected 05 1", bus.dout, bus.dout_en);
      end
      bus.sb = 1'b0;
      #1;
      n_vec++;
      if (bus.dout !== 8'h00 || bus.dout_en !== 1'b0) begin
         n_bad++;
         $display("FAIL dout_off: dout=%h en=%b, expected 00 0", bus.dout, bus.dout_en);
      end
   endtask

   task automatic test_flags();
      op_t  ops[$];
      exp_t e;
      ops.push_back(mk_ld(1, 8'h10, 1'b0));
      ops.push_back(mk_alu(FS_SUB, 1, 1, 0, 0, 8'h00, 0, 0, 1));
      ops.push_back(mk_alu(FS_ADD, 1, 0, 0, 1, 8'h03, 0, 0, 0));
      ops.push_back(mk_ld(2, 8'h7F, 1'b0));
      ops.push_back(mk_alu(FS_ADD, 2, 0, 0, 1, 8'h01, 0, 0, 1));
      ops.push_back(mk_ld(4, 8'h00, 1'b0));
      ops.push_back(mk_alu(FS_SUB, 4, 0, 0, 1, 8'h01, 0, 0, 1));
      ops.push_back(mk_ld(5, 8'h80, 1'b1));
      foreach (ops[i]) begin
         issue(ops[i]);
         e = sb_q.pop_front();
         n_vec++;
         if (bus.f_valid !== 1'b1 || bus.f !== e.f || bus.status !== e.st) begin
            n_bad++;
            $display("FAIL flags[%0d]: f_valid=%b f=%h status=%b, expected 1 %h %b",
                     i, bus.f_valid, bus.f, bus.status, e.f, e.st);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] fs_list [12];
      op_t        ops[$];
      exp_t       e;
      fs_list = '{FS_AND, FS_OR, FS_XOR, FS_NOR, FS_ADD, FS_SUB, FS_LSL, FS_LSR, FS_ADD,
                  FS_PASSB, 4'd10, 4'd15};
      for (int it = 0; it < 3; it++) begin
         ops.push_back(mk_ld(5, 8'($urandom), 1'b0));
         ops.push_back(mk_ld(6, 8'($urandom), 1'b0));
         foreach (fs_list[j]) begin
            ops.push_back(mk_alu(fs_list[j], 5, 6, 5, 1'(it == 1), 8'($urandom),
                                 1'(j == 8), 1'b1, 1'b1));
         end
      end
      foreach (ops[i]) begin
         issue(ops[i]);
         e = sb_q.pop_front();
         n_vec++;
         if (bus.f_valid !== 1'b1 || bus.f !== e.f || bus.status !== e.st) begin
            n_bad++;
            $display("FAIL b2b[%0d] fs=%0d: f_valid=%b f=%h status=%b, expected 1 %h %b",
                     i, ops[i].fs, bus.f_valid, bus.f, bus.status, e.f, e.st);
         end
      end
   endtask

   task automatic test_mul();
      exp_t e;
      op_t  pre[$];
      pre.push_back(mk_ld(1, 8'h0D, 1'b0));
      pre.push_back(mk_ld(2, 8'h0B, 1'b0));
      foreach (pre[i]) begin
         issue(pre[i]);
         e = sb_q.pop_front();
         n_vec++;
         if (bus.f_valid !== 1'b1 || bus.f !== e.f) begin
            n_bad++;
            $display("FAIL mul_ld[%0d]: f_valid=%b f=%h, expected 1 %h",
                     i, bus.f_valid, bus.f, e.f);
         end
      end
      model_op(mk_alu(FS_MUL, 1, 2, 3, 0, 8'h00, 0, 1, 1));
      drive(mk_alu(FS_MUL, 1, 2, 3, 0, 8'h00, 0, 1, 1));
      @(posedge clk);
      @(negedge clk);
      // Offered while busy; must be dropped, so it is not modelled.
      drive(mk_alu(FS_ADD, 0, 0, 4, 1, 8'h55, 0, 1, 1));
      for (int i = 1; i <= W; i++) begin
         n_vec++;
         if (bus.in_ready !== 1'b0 || bus.f_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mul_busy[N+%0d]: in_ready=%b f_valid=%b, expected 0 0",
                     i, bus.in_ready, bus.f_valid);
         end
         if (i == W) bus.in_valid = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
      e = sb_q.pop_front();
      n_vec++;
      if (bus.f_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.f !== e.f || bus.status !== e.st)
      begin
         n_bad++;
         $display("FAIL mul_done: f_valid=%b in_ready=%b f=%h status=%b, expected 1 1 %h %b",
                  bus.f_valid, bus.in_ready, bus.f, bus.status, e.f, e.st);
      end
      @(negedge clk);
      n_vec++;
      if (bus.f_valid !== 1'b0 || bus.f !== e.f) begin
         n_bad++;
         $display("FAIL mul_hold: f_valid=%b f=%h, expected 0 %h", bus.f_valid, bus.f, e.f);
      end
      issue(mk_alu(FS_PASSB, 0, 3, 0, 0, 8'h00, 0, 0, 0));
      e = sb_q.pop_front();
      n_vec++;
      if (bus.f_valid !== 1'b1 || bus.f !== e.f || bus.status !== e.st) begin
         n_bad++;
         $display("FAIL mul_wb: f=%h status=%b, expected %h %b", bus.f, bus.status, e.f, e.st);
      end
   endtask

   task automatic test_zero_reg();
      op_t  ops[$];
      exp_t e;
      ops.push_back(mk_ld(ZR, 8'hFF, 1'b0));
      ops.push_back(mk_alu(FS_PASSB, 0, ZR, 0, 0, 8'h00, 0, 0, 0));
      ops.push_back(mk_alu(FS_ADD, ZR, 0, 0, 1, 8'h00, 0, 0, 1));
      foreach (ops[i]) begin
         issue(ops[i]);
         e = sb_q.pop_front();
         n_vec++;
         if (bus.f_valid !== 1'b1 || bus.f !== e.f || bus.status !== e.st) begin
            n_bad++;
            $display("FAIL zero_reg[%0d]: f_valid=%b f=%h status=%b, expected 1 %h %b",
                     i, bus.f_valid, bus.f, bus.status, e.f, e.st);
         end
      end
   endtask

   task automatic test_reset_mid_mul();
      exp_t e;
      issue(mk_ld(2, 8'h99, 1'b1));
      void'(sb_q.pop_front());
      drive(mk_alu(FS_MUL, 2, 2, 1, 0, 8'h00, 0, 1, 1));
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.f !== '0 || bus.f_valid !== 1'b0 || bus.status !== 4'h0 || bus.in_ready !== 1'b1)
      begin
         n_bad++;
         $display("FAIL rst_mul: f=%h f_valid=%b status=%b in_ready=%b, expected 00 0 0000 1",
                  bus.f, bus.f_valid, bus.status, bus.in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NR; i++) mreg[i] = '0;
      mstat = '0;
      sb_q.delete();
      @(negedge clk);
      n_vec++;
      if (bus.in_ready !== 1'b1 || bus.f_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_release: in_ready=%b f_valid=%b, expected 1 0",
                  bus.in_ready, bus.f_valid);
      end
      bus.sb = 1'b1;
      bus.sd = 1'b0;
      for (int i = 0; i < NR; i++) begin
         bus.addr_b = AWT'(i);
         #1;
         n_vec++;
         if (bus.dout !== '0 || bus.dout_en !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_reg[%0d]: dout=%h en=%b, expected 00 1", i, bus.dout, bus.dout_en);
         end
      end
      bus.sb = 1'b0;
      @(negedge clk);
      issue(mk_alu(FS_ADD, 2, 0, 0, 1, 8'h3C, 0, 0, 1));
      e = sb_q.pop_front();
      n_vec++;
      if (bus.f_valid !== 1'b1 || bus.f !== e.f || bus.status !== e.st) begin
         n_bad++;
         $display("FAIL rst_after: f=%h status=%b, expected %h %b", bus.f, bus.status, e.f, e.st);
      end
   endtask

   initial begin
      test_reset();
      test_fwd_add();
      test_flags();
      test_back_to_back();
      test_mul();
      test_zero_reg();
      test_reset_mid_mul();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_reg_pipe.md
Name: alu_reg_pipe

Overview:
Parametrised, pipelined successor to the single-cycle register-file + ALU datapath.
- Register file is NREGS x WIDTH with 2 read ports and 1 write port, and an optional hardwired zero register.
- Result is registered, and writeback happens one cycle later with operand forwarding.
- Adds a multi-cycle iterative multiply with a valid/ready issue handshake and a sticky status register updated on request.
- Sits between the control unit (issues ops) and the memory/IO bus (dout).

Parameters:
WIDTH, 64, datapath width (>=8, power of 2)
NREGS, 32, register count (power of 2)
ZR_EN, 1, when 1 register NREGS-1 reads 0 and ignores writes
AW, $clog2(NREGS), register address width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  op issue request
in_ready  out  1  block can accept an op
addrA, addrB, addrR  in  AW  read A, read B, write register addresses
fs  in  4  function select
s  in  1  B-mux select: 0=regB, 1=k
k  in  WIDTH  immediate
c0  in  1  carry in for ADD
ld  in  1  1 = result is din (load), ALU bypassed
din  in  WIDTH  load data
w  in  1  write result to addrR
set_flags  in  1  update status on completion
sb, sd  in  1  dout drive selects
f  out  WIDTH  registered result
f_valid  out  1  f holds a newly completed result this cycle
status  out  4  {V,C,N,Z}, registered
dout  out  WIDTH  sd ? f : sb ? forwarded B operand : 0
dout_en  out  1  sb | sd

Behaviour:
- Reset (rst=0, async): all regs 0, f=0, f_valid=0, status=0, FSM=IDLE, any multiply aborted, pending writeback dropped. in_ready=1 after release.
- Accept = in_valid & in_ready; all op inputs are sampled in the accept cycle N.
- Operand read (cycle N): the registered operand is replaced by f whenever a writeback is pending (wb_pend = f_valid & w_q) and addrR_q == addr. The zero register is never forwarded and reads 0.
- fs codes:
  - 0 AND, 1 OR, 2 XOR, 3 NOR
  - 4 ADD = A+B+c0
  - 5 SUB = A+~B+1
  - 6 LSL = A<<B[log2W-1:0], 7 LSR = A>>B[log2W-1:0]
  - 8 PASSB
  - 9 MUL = low WIDTH bits of A*B
  - 10-15 result 0
- Flags:
  - Z = (res==0)
  - N = res[WIDTH-1]
  - C = carry out for ADD/SUB, else 0
  - V = signed overflow for ADD/SUB, else 0
  - ld: Z/N from din, C=V=0
  - status loads only at completion with set_flags=1, otherwise holds.
- Single-cycle ops and ld: f, f_valid=1 in cycle N+1. Back-to-back accepts give f_valid every cycle.
- Writeback: on the edge ending the cycle where f_valid & w_q, regfile[addrR_q] <= f. Writes to the zero register (ZR_EN) are discarded.
- FSM IDLE/MUL:
  - MUL accept latches forwarded A, B, addrR, w, set_flags; goes IDLE->MUL; in_ready=0.
  - Shift-add runs 1 bit/cycle for WIDTH cycles (N+1..N+WIDTH).
  - At the edge ending N+WIDTH the product goes to f; f_valid=1 and in_ready=1 in N+WIDTH+1; FSM->IDLE.
  - f_valid is 0 during MUL cycles, and any earlier result still writes back normally.
- in_ready = (FSM==IDLE). in_valid while in_ready=0 is ignored (no queue).
- f holds its value when f_valid=0.

Decomposition:
- Package alu_reg_pkg: fs code localparams (FS_AND..FS_MUL), status bit indices (ST_Z=0, ST_N=1, ST_C=2, ST_V=3), FSM state encoding.
- One sub-module regfile_2r1w (WIDTH, NREGS, ZR_EN): async read, sync write, async active-low clear. Forwarding stays in alu_reg_pipe.

Test Plan:
1. Reset then ld din=0x5 w=1 addrR=3; next cycle ADD addrA=3 s=1 k=0x7 c0=0 -> forwarded A=5; f=0xC in following cycle; regfile[3]=5.
2. SUB A=B=0x10 set_flags=1 -> f=0, status Z=1 C=1 N=0 V=0. Next ADD with set_flags=0 leaves status unchanged.
3. WIDTH=8: ADD 0x7F+0x01 set_flags -> f=0x80, N=1 V=1 C=0. SUB 0x00-0x01 -> f=0xFF, N=1 C=0.
4. WIDTH=8 MUL 0x0D*0x0B issued cycle N -> in_ready=0 for N+1..N+8; f=0x8F with f_valid=1 in N+9; second in_valid during busy is ignored.
5. ZR_EN=1: ld din=0xFF w=1 addrR=NREGS-1, then PASSB addrB=NREGS-1 -> f=0 (no forwarding, no write).
6. Assert rst low mid-MUL (cycle N+4) -> f=0, f_valid=0, status=0, in_ready=1 after release, all regs read 0; sb=1 sd=0 -> dout=0, dout_en=1.
